// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions: datapath width, canonical NOP, reset PC and fetch FSM states.
package rv32i_pkg;

    localparam int unsigned       XLEN     = 32;
    localparam logic [XLEN-1:0]   INST_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0]   RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures pc/pc4/inst every cycle unless held or flushed.
module if_id_reg
    import rv32i_pkg::*;
#(
    parameter int unsigned N = XLEN
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_hold,
    input  logic         i_flush,
    input  logic [N-1:0] i_pc,
    input  logic [N-1:0] i_inst,
    output logic         o_valid,
    output logic [N-1:0] o_pc,
    output logic [N-1:0] o_pc4,
    output logic [N-1:0] o_inst
);

    localparam logic [N-1:0] L_NOP = N'(INST_NOP);

    logic         r_valid;
    logic [N-1:0] r_pc;
    logic [N-1:0] r_pc4;
    logic [N-1:0] r_inst;

    // Flush beats hold so a redirect during back-pressure still drops the wrong-path word.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_pc4   <= '0;
            r_inst  <= L_NOP;
        end else if (!i_hold) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_pc4   <= i_pc + N'(4);
            r_inst  <= i_inst;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_pc4   = r_pc4;
    assign o_inst  = r_inst;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC register, next-PC selection, fetch FSM and misaligned-target fault.
module fetch_stage
    import rv32i_pkg::*;
#(
    parameter int unsigned     N        = XLEN,
    parameter logic [N-1:0]    RESET_PC = rv32i_pkg::RESET_PC
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_fetch_en,
    input  logic         i_stall,
    input  logic         i_redirect,
    input  logic [N-1:0] i_redirect_pc,
    output logic [N-1:0] o_imem_addr,
    input  logic [N-1:0] i_imem_inst,
    output logic         o_ifid_valid,
    output logic [N-1:0] o_ifid_pc,
    output logic [N-1:0] o_ifid_pc4,
    output logic [N-1:0] o_ifid_inst,
    output logic         o_fault,
    output logic [N-1:0] o_fault_pc
);

    fetch_state_e r_state;
    fetch_state_e w_state_d;
    logic [N-1:0] r_pc;
    logic [N-1:0] w_pc_d;
    logic         r_fault;
    logic         w_fault_d;
    logic [N-1:0] r_fault_pc;
    logic [N-1:0] w_fault_pc_d;
    logic         w_hold;
    logic         w_flush;
    logic         w_misaligned;

    assign w_misaligned = |i_redirect_pc[1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_fault    <= 1'b0;
            r_fault_pc <= '0;
        end else begin
            r_state    <= w_state_d;
            r_pc       <= w_pc_d;
            r_fault    <= w_fault_d;
            r_fault_pc <= w_fault_pc_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_pc_d       = r_pc;
        w_fault_d    = r_fault;
        w_fault_pc_d = r_fault_pc;
        w_hold       = 1'b0;
        w_flush      = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_flush = 1'b1;
                if (i_fetch_en) begin
                    w_state_d = RUN;
                end
            end
            RUN: begin
                if (i_redirect) begin
                    w_flush = 1'b1;
                    if (w_misaligned) begin
                        w_state_d    = FAULT;
                        w_fault_d    = 1'b1;
                        w_fault_pc_d = i_redirect_pc;
                    end else begin
                        w_pc_d = i_redirect_pc;
                    end
                end else if (i_stall) begin
                    w_hold = 1'b1;
                end else if (!i_fetch_en) begin
                    w_state_d = IDLE;
                    w_flush   = 1'b1;
                end else begin
                    w_pc_d = r_pc + N'(4);
                end
            end
            FAULT: begin
                w_flush = 1'b1;
            end
            default: begin
                w_state_d = IDLE;
                w_flush   = 1'b1;
            end
        endcase
    end

    if_id_reg #(
        .N (N)
    ) u_if_id_reg (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_hold  (w_hold),
        .i_flush (w_flush),
        .i_pc    (r_pc),
        .i_inst  (i_imem_inst),
        .o_valid (o_ifid_valid),
        .o_pc    (o_ifid_pc),
        .o_pc4   (o_ifid_pc4),
        .o_inst  (o_ifid_inst)
    );

    assign o_imem_addr = r_pc;
    assign o_fault     = r_fault;
    assign o_fault_pc  = r_fault_pc;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RV32I core. Sits directly upstream of `Instruction_Mem`: owns the program counter, drives the memory word address, and captures the returned instruction into the IF/ID pipeline register consumed by decode. Handles stall, control-flow redirect with flush, fetch enable, and misaligned-target fault.

## Interface
Parameters:
- `N`, 32, datapath/address width.
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.

Ports:
- `i_clk`  in  1  core clock; all state updates on rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_fetch_en`  in  1  1 = fetch allowed; 0 = idle, hold PC.
- `i_stall`  in  1  hold PC and IF/ID contents (decode back-pressure).
- `i_redirect`  in  1  taken branch/jump this cycle.
- `i_redirect_pc`  in  N  redirect target.
- `o_imem_addr`  out  N  byte address to instruction memory (= PC register).
- `i_imem_inst`  in  N  instruction word returned combinationally for `o_imem_addr`.
- `o_ifid_valid`  out  1  IF/ID entry holds a real instruction.
- `o_ifid_pc`  out  N  PC of IF/ID instruction.
- `o_ifid_pc4`  out  N  `o_ifid_pc` + 4.
- `o_ifid_inst`  out  N  instruction; NOP (32'h0000_0013) when not valid.
- `o_fault`  out  1  sticky misaligned-fetch fault.
- `o_fault_pc`  out  N  offending redirect target.

## Operation
- States: IDLE, RUN, FAULT. Reset -> IDLE.
- IDLE: PC held, IF/ID valid=0, inst=NOP. `i_fetch_en`=1 -> RUN.
- RUN, per cycle, priority highest first:
  - `i_redirect` with `i_redirect_pc[1:0]`≠0 -> FAULT; `o_fault`=1, `o_fault_pc`=target; PC held; IF/ID flushed (valid=0).
  - `i_redirect` aligned: PC <= `i_redirect_pc`; IF/ID flushed. Redirect overrides `i_stall` and `i_fetch_en`=0 (target is still loaded).
  - `i_stall`: PC and IF/ID hold all values.
  - `i_fetch_en`=0: -> IDLE; PC held; IF/ID valid <= 0.
  - else: IF/ID <= {valid=1, pc=PC, pc4=PC+4, inst=`i_imem_inst`}; PC <= PC+4.
- FAULT: terminal; PC held, IF/ID valid=0, fault outputs stable; exit only via `i_rst`.
- PC+4 wraps modulo 2^N (32'hFFFF_FFFC -> 32'h0000_0000), no flag.
- `o_imem_addr[1:0]` always 00 except never reachable otherwise; memory indexes by `[.. :2]`.

## Timing
- Reset values: PC=`RESET_PC`, `o_imem_addr`=`RESET_PC`, `o_ifid_valid`=0, `o_ifid_pc`=0, `o_ifid_pc4`=0, `o_ifid_inst`=NOP, `o_fault`=0, `o_fault_pc`=0, state IDLE.
- `i_rst` asserted mid-operation: all of the above at the next edge, regardless of stall/redirect/fault.
- `o_imem_addr` is a register output; no combinational path from any input.
- Fetch latency 1 cycle: word addressed in cycle t appears on `o_ifid_*` in t+1.
- Redirect asserted in cycle t: `o_imem_addr`=target in t+1; target instruction valid on IF/ID in t+2; exactly one bubble.
- Stall in cycle t: all outputs in t+1 identical to t.
- IDLE->RUN: first valid IF/ID two cycles after `i_fetch_en` rises (one for state, one for fetch).

## Structure
- Package `rv32i_pkg`: `fetch_state_e` (IDLE, RUN, FAULT), `XLEN`=32, `INST_NOP`=32'h0000_0013, `RESET_PC` default.
- One sub-module natural: `if_id_reg` (valid/pc/pc4/inst register with hold and flush inputs); PC register, next-PC mux and FSM stay in `fetch_stage`.

## Test plan
- Reset, `i_fetch_en`=1, memory model returns 0x002081b3 at 0x4 -> addr 0,4,8 on successive cycles; IF/ID shows pc=0x4, pc4=0x8, inst=0x002081b3, valid=1.
- `i_stall` for 3 cycles at PC=0x10 -> addr stays 0x10, IF/ID unchanged, resumes 0x14 on release.
- `i_redirect`=1, target 0x100, simultaneous `i_stall`=1 -> next addr 0x100, IF/ID valid=0 inst=NOP, 0x100 instruction valid one cycle later.
- Redirect target 0x102 -> `o_fault`=1, `o_fault_pc`=0x102, valid stays 0, PC frozen until `i_rst`; then all outputs return to reset values.
- PC=0xFFFF_FFFC, no stall -> next addr 0x0, IF/ID pc4=0x0.
- `i_fetch_en` dropped for 2 cycles at PC=0x20 -> valid=0, addr held 0x20; re-enable -> 0x20 fetched, no skipped or duplicated PC.
